fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Generates the 2-bit select codes for the EX-stage operand forwarding muxes (4:1, 32-bit) in the 5-stage RV32I pipeline.
- Also produces the load-use stall and branch-flush controls.
- Keeps its own shadow copy of each instruction's register usage as it moves through EX, MEM and WB, so the datapath only presents decode-stage fields.
- Sits beside the controller and drives the operand muxes, the IF/ID and ID/EX pipeline-register enables and clears, and the PC enable.

Parameters:
- REG_AW, 5, register-address width (x0..x31).
- CNT_W, 16, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d  in  REG_AW  source register 1 of the instruction in decode.
- rs2_d  in  REG_AW  source register 2 of the instruction in decode.
- rd_d  in  REG_AW  destination register of the instruction in decode.
- regwrite_d  in  1  decode instruction writes rd.
- load_d  in  1  decode instruction is a load (result comes from data memory).
- link_d  in  1  decode instruction is JAL/JALR (result is PC+4).
- pc_src_e  in  1  taken branch/jump resolved in EX this cycle.
- fwd_a_e  out  2  select for operand-A mux.
- fwd_b_e  out  2  select for operand-B mux.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID.
- flush_d  out  1  clear IF/ID.
- flush_e  out  1  clear ID/EX (insert bubble).
- stall_cnt  out  CNT_W  count of load-use stall cycles.

Behaviour:
- Shadow pipeline registers, all updated on the rising clock edge:
  - EX stage: rs1_e, rs2_e, rd_e, regwrite_e, load_e, link_e.
  - MEM stage: rd_m, regwrite_m, load_m, link_m.
  - WB stage: rd_w, regwrite_w.
- Reset (rst_n low, asynchronous):
  - All shadow fields cleared; the regwrite, load and link flags are 0.
  - All outputs are 0 and stall_cnt is 0.
  - Outputs remain 0 for as long as rst_n is low.
- Each clock edge:
  - MEM stage takes the EX-stage fields; WB stage takes the MEM-stage fields.
  - EX stage takes the decode inputs, unless flush_e=1. In that case the EX stage takes a bubble: every field 0.
- Forward select, evaluated combinationally from the shadow state, for operand A using rs1_e (operand B identical using rs2_e):
  - 2'b00 when the source register is x0, or when there is no match.
  - 2'b10 (MEM ALU result) when regwrite_m && rd_m==rs && !link_m.
  - 2'b11 (MEM PC+4) when regwrite_m && rd_m==rs && link_m.
  - 2'b01 (WB result) when regwrite_w && rd_w==rs.
  - Priority: MEM match over WB match; an x0 source always gives 00.
  - Zero latency relative to the EX state.
- Load-use detection:
  - lw_stall = load_e && regwrite_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - The test uses both sources unconditionally (conservative).
- Control outputs (combinational):
  - stall_f = stall_d = lw_stall && !pc_src_e.
  - flush_d = pc_src_e.
  - flush_e = lw_stall || pc_src_e.
- Simultaneous load-use and taken branch: the branch wins. No stall is raised; IF/ID and ID/EX are both flushed, because the decode instruction is on the wrong path.
- A load followed by a dependent instruction stalls exactly one cycle. After the bubble, the load is in WB and the select is 01.
- stall_cnt increments on every edge with stall_d=1 and saturates at all-ones; there is no wrap-around.
- A load in MEM is never a forwarding source. The stall guarantees this case cannot arise.
- Reset in mid-operation clears the shadow pipeline immediately. The first instruction after reset sees selects of 00.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles while driving random inputs -> all outputs 0 and stall_cnt=0; release -> outputs remain 0 until the shadow state is populated.
- Back-to-back ALU: add x5 (regwrite), then sub using rs1=x5 -> fwd_a_e=10 in the sub's EX cycle. Insert one unrelated instruction between them -> fwd_a_e=01.
- JAL link forward: jal x1, then an instruction with rs2=x1 -> fwd_b_e=11. With rd=x0 and rs2=x0 -> 00.
- Double hazard: x7 written in both MEM and WB, consumer has rs1=rs2=x7 -> fwd_a_e=fwd_b_e=10.
- Load-use: lw x3, then add rs1=x3 -> one cycle with stall_f=stall_d=flush_e=1, then fwd_a_e=01, and stall_cnt increments by 1. Same sequence with pc_src_e=1 in the stall cycle -> stall_d=0, flush_d=flush_e=1, and stall_cnt unchanged.
- Saturation: with CNT_W=4, force 20 load-use stalls -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus load-use stall and branch flush control.
// Tracks register usage of in-flight instructions in a private shadow pipe.
module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              regwrite_d,
  input  logic              load_d,
  input  logic              link_d,
  input  logic              pc_src_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] r_rs1_e;
  logic [REG_AW-1:0] r_rs2_e;
  logic [REG_AW-1:0] r_rd_e;
  logic              r_rw_e;
  logic              r_ld_e;
  logic              r_lk_e;
  logic [REG_AW-1:0] r_rd_m;
  logic              r_rw_m;
  logic              r_ld_m;
  logic              r_lk_m;
  logic [REG_AW-1:0] r_rd_w;
  logic              r_rw_w;
  logic [CNT_W-1:0]  r_cnt;

  logic w_lw_stall;
  logic w_pc_src;
  logic w_stall;
  logic w_flush_e;

  // MEM beats WB; a load still in MEM has no data yet
  function automatic logic [1:0] sel(
    input logic [REG_AW-1:0] rs
  );
    if (rs == '0)
      sel = 2'b00;
    else if (r_rw_m && !r_ld_m && r_rd_m == rs)
      sel = r_lk_m ? 2'b11 : 2'b10;
    else if (r_rw_w && r_rd_w == rs)
      sel = 2'b01;
    else
      sel = 2'b00;
  endfunction

  assign fwd_a_e = sel(r_rs1_e);
  assign fwd_b_e = sel(r_rs2_e);

  assign w_lw_stall = r_ld_e && r_rw_e
                   && (r_rd_e != '0)
                   && (r_rd_e == rs1_d
                    || r_rd_e == rs2_d);

  assign w_pc_src  = pc_src_e && rst_n;
  assign w_stall   = w_lw_stall && !w_pc_src;
  assign w_flush_e = w_lw_stall || w_pc_src;

  assign stall_f   = w_stall;
  assign stall_d   = w_stall;
  assign flush_d   = w_pc_src;
  assign flush_e   = w_flush_e;
  assign stall_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs1_e <= '0;
      r_rs2_e <= '0;
      r_rd_e  <= '0;
      r_rw_e  <= 1'b0;
      r_ld_e  <= 1'b0;
      r_lk_e  <= 1'b0;
      r_rd_m  <= '0;
      r_rw_m  <= 1'b0;
      r_ld_m  <= 1'b0;
      r_lk_m  <= 1'b0;
      r_rd_w  <= '0;
      r_rw_w  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rd_m <= r_rd_e;
      r_rw_m <= r_rw_e;
      r_ld_m <= r_ld_e;
      r_lk_m <= r_lk_e;
      r_rd_w <= r_rd_m;
      r_rw_w <= r_rw_m;
      if (w_flush_e) begin
        r_rs1_e <= '0;
        r_rs2_e <= '0;
        r_rd_e  <= '0;
        r_rw_e  <= 1'b0;
        r_ld_e  <= 1'b0;
        r_lk_e  <= 1'b0;
      end else begin
        r_rs1_e <= rs1_d;
        r_rs2_e <= rs2_d;
        r_rd_e  <= rd_d;
        r_rw_e  <= regwrite_d;
        r_ld_e  <= load_d;
        r_lk_e  <= link_d;
      end
      if (w_stall && r_cnt != '1)
        r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: expected selects queued at issue,
// checked when the instruction reaches EX; a 4-bit counter copy for saturation.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d = '0;
  logic [4:0] rs2_d = '0;
  logic [4:0] rd_d = '0;
  logic       regwrite_d = 1'b0;
  logic       load_d = 1'b0;
  logic       link_d = 1'b0;
  logic       pc_src_e = 1'b0;

  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [15:0] stall_cnt;

  logic [1:0] s_fa, s_fb;
  logic       s_sf, s_sd, s_fd, s_fe;
  logic [3:0] s_cnt;

  int checks = 0;
  int errors = 0;
  logic [3:0]  q[$];
  logic [15:0] exp16 = '0;
  logic [3:0]  exp4 = '0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d),
    .link_d(link_d), .pc_src_e(pc_src_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e),
    .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .load_d(load_d),
    .link_d(link_d), .pc_src_e(pc_src_e),
    .fwd_a_e(s_fa), .fwd_b_e(s_fb),
    .stall_f(s_sf), .stall_d(s_sd),
    .flush_d(s_fd), .flush_e(s_fe),
    .stall_cnt(s_cnt)
  );

  // One decode cycle: ea/eb are the selects this instruction must see in EX
  task automatic cyc(
    input logic [4:0] rs1, rs2, rd,
    input logic rw, ld, lk, pc,
    input logic [1:0] ea, eb,
    input logic es, ef,
    input string nm
  );
    logic [3:0] e;
    @(negedge clk);
    rs1_d = rs1; rs2_d = rs2; rd_d = rd;
    regwrite_d = rw; load_d = ld;
    link_d = lk; pc_src_e = pc;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({fwd_a_e, fwd_b_e} !== e ||
          {s_fa, s_fb} !== e) begin
        errors++;
        $display("FAIL fwd@%s got a=%b b=%b req a=%b b=%b",
                 nm, fwd_a_e, fwd_b_e, e[3:2], e[1:0]);
      end
    end
    checks++;
    if ({stall_f, stall_d, flush_d, flush_e} !==
        {es, es, pc, ef}) begin
      errors++;
      $display("FAIL ctl@%s got sf/sd/fd/fe=%b req %b",
               nm, {stall_f, stall_d, flush_d, flush_e},
               {es, es, pc, ef});
    end
    checks++;
    if (stall_cnt !== exp16 || s_cnt !== exp4) begin
      errors++;
      $display("FAIL cnt@%s got %0d/%0d req %0d/%0d",
               nm, stall_cnt, s_cnt, exp16, exp4);
    end
    q.push_back(ef ? 4'b0000 : {ea, eb});
    if (es) begin
      exp16 = exp16 + 16'd1;
      if (exp4 != 4'hF) exp4 = exp4 + 4'd1;
    end
  endtask

  task automatic nop();
    cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, "nop");
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp16 = '0;
    exp4 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {rs1_d, rs2_d, rd_d} = 15'($urandom);
      {regwrite_d, load_d, link_d, pc_src_e} = 4'($urandom);
      if (i == 0) pc_src_e = 1'b1;
      #1;
      checks++;
      if ({fwd_a_e, fwd_b_e, stall_f, stall_d,
           flush_d, flush_e} !== 8'h00 ||
          stall_cnt !== 16'd0 || s_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold got fa=%b fb=%b ctl=%b cnt=%0d",
                 fwd_a_e, fwd_b_e,
                 {stall_f, stall_d, flush_d, flush_e},
                 stall_cnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    {rs1_d, rs2_d, rd_d} = '0;
    {regwrite_d, load_d, link_d, pc_src_e} = '0;
    #1;
    checks++;
    if ({fwd_a_e, fwd_b_e, stall_f, stall_d,
         flush_d, flush_e} !== 8'h00 ||
        stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got fa=%b fb=%b ctl=%b req 0",
               fwd_a_e, fwd_b_e,
               {stall_f, stall_d, flush_d, flush_e});
    end
    q.delete();
    q.push_back(4'b0000);
  endtask

  task automatic test_alu_fwd();
    nop(); nop();
    cyc(1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "add_x5");
    cyc(5, 6, 8, 1, 0, 0, 0, 2'b10, 2'b00, 0, 0, "sub_mem");
    nop(); nop();
    cyc(1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "add_x5b");
    cyc(9, 10, 11, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "other");
    cyc(5, 6, 8, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, "sub_wb");
    nop();
  endtask

  task automatic test_jal_fwd();
    nop(); nop();
    cyc(0, 0, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "jal_x1");
    cyc(0, 1, 2, 1, 0, 0, 0, 2'b00, 2'b11, 0, 0, "use_x1");
    cyc(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, "jal_x0");
    cyc(0, 0, 4, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "use_x0");
    nop();
  endtask

  task automatic test_double();
    nop(); nop();
    cyc(1, 2, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "w7_a");
    cyc(3, 4, 7, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "w7_b");
    cyc(7, 7, 9, 1, 0, 0, 0, 2'b10, 2'b10, 0, 0, "use_77");
    nop();
  endtask

  task automatic test_load_use();
    nop(); nop();
    cyc(0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_x3");
    cyc(3, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, "add_stall");
    cyc(3, 0, 6, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, "add_go");
    nop(); nop();
    cyc(0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_x3b");
    cyc(0, 3, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, "rs2_stall");
    cyc(0, 3, 6, 1, 0, 0, 0, 2'b00, 2'b01, 0, 0, "rs2_go");
    nop();
  endtask

  task automatic test_load_branch();
    nop(); nop();
    cyc(0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_br");
    cyc(3, 0, 6, 1, 0, 0, 1, 2'b00, 2'b00, 0, 1, "br_win");
    nop(); nop();
  endtask

  task automatic test_mid_reset();
    nop();
    cyc(0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "lw_pre");
    test_reset();
    cyc(3, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, "post_rst");
    nop();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, "sat_lw");
      cyc(3, 0, 6, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1, "sat_st");
      cyc(3, 0, 6, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, "sat_go");
    end
    nop();
    checks++;
    if (s_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat_hold got %h req F", s_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_fwd();
    test_jal_fwd();
    test_double();
    test_load_use();
    test_load_branch();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
